// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : Shared encodings for the data-memory controller and aligner.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LANE_BYTE0   = 4'b0001;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_WORD    = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_lsu_align
//  Purpose  : Combinational byte-lane steering for stores and load extension.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        ld_unsigned,
  input  logic [31:0] wr_dat,
  input  logic [31:0] ram_word,
  output logic [3:0]  wr_strb,
  output logic [31:0] wr_word,
  output logic [31:0] ld_dat
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wr_strb = 4'b0000;
    wr_word = wr_dat;
    ld_dat  = ram_word;
    case (off)
      2'd0:    ld_byte = ram_word[7:0];
      2'd1:    ld_byte = ram_word[15:8];
      2'd2:    ld_byte = ram_word[23:16];
      default: ld_byte = ram_word[31:24];
    endcase
    ld_half = off[1] ? ram_word[31:16] : ram_word[15:0];

    // Replicating narrow data onto every lane lets the strobe alone pick the target.
    case (size)
      SZ_BYTE: begin
        wr_strb = LANE_BYTE0 << off;
        wr_word = {4{wr_dat[7:0]}};
        ld_dat  = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        wr_strb = off[1] ? LANE_HALF_HI : LANE_HALF_LO;
        wr_word = {2{wr_dat[15:0]}};
        ld_dat  = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      end
      SZ_WORD: wr_strb = LANE_WORD;
      default: wr_strb = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_dmem_ctrl
//  Purpose  : Data-memory controller: sub-word access, wait states, faults.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wr_dat,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] m_rd_dat,
  output logic        stall,
  output logic        err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d, size_q, size_d;
  logic            uns_q, uns_d, fault_q, fault_d, wr_q, wr_d;
  logic [31:0]     m_rd_dat_q, m_rd_dat_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [31:0]     w_offset, w_ram_word, w_wr_word, w_ld_dat;
  logic            w_req, w_fault, w_enter_done;
  logic [AW-1:0]   a_idx;
  logic [1:0]      a_off, a_size;
  logic            a_uns, a_fault, a_wr;
  logic [3:0]      w_wr_strb;

  assign w_req    = rd_en | wr_en;
  assign w_offset = m_addr - BASE_ADDR;
  assign w_fault  = (rd_en & wr_en) | (size == 2'b11)
                  | ((size == SZ_HALF) & m_addr[0])
                  | ((size == SZ_WORD) & (m_addr[1:0] != 2'b00))
                  | (m_addr < BASE_ADDR) | ({1'b0, w_offset} >= MEM_BYTES);

  // With zero wait states the access completes straight out of IDLE, so the
  // live request is used there; otherwise the latched copy drives the access.
  always_comb begin
    if (state_q == IDLE) begin
      a_idx = w_offset[AW+1:2]; a_off = m_addr[1:0]; a_size = size;
      a_uns = ld_unsigned;      a_fault = w_fault;   a_wr = wr_en;
    end else begin
      a_idx = idx_q; a_off = off_q; a_size = size_q;
      a_uns = uns_q; a_fault = fault_q; a_wr = wr_q;
    end
  end

  assign w_ram_word = mem[a_idx];

  riscv_lsu_align u_align (
    .size        (a_size),
    .off         (a_off),
    .ld_unsigned (a_uns),
    .wr_dat      (m_wr_dat),
    .ram_word    (w_ram_word),
    .wr_strb     (w_wr_strb),
    .wr_word     (w_wr_word),
    .ld_dat      (w_ld_dat)
  );

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; idx_d = idx_q; off_d = off_q; size_d = size_q;
    uns_d = uns_q; fault_d = fault_q; wr_d = wr_q; m_rd_dat_d = m_rd_dat_q;
    case (state_q)
      IDLE: if (w_req) begin
        idx_d = a_idx; off_d = a_off; size_d = a_size;
        uns_d = a_uns; fault_d = a_fault; wr_d = a_wr;
        if (WAIT_STATES == 0) begin
          state_d = DONE;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 3'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 3'd1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_d == DONE) && (state_q != DONE)) begin
      if (a_fault)    m_rd_dat_d = '0;
      else if (!a_wr) m_rd_dat_d = w_ld_dat;
    end
  end

  assign w_enter_done = reset & (state_d == DONE) & (state_q != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE; cnt_q <= '0; idx_q <= '0; off_q <= '0; size_q <= '0;
      uns_q <= 1'b0; fault_q <= 1'b0; wr_q <= 1'b0; m_rd_dat_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; idx_q <= idx_d; off_q <= off_d; size_q <= size_d;
      uns_q <= uns_d; fault_q <= fault_d; wr_q <= wr_d; m_rd_dat_q <= m_rd_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_done & a_wr & ~a_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_strb[i]) mem[a_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
      end
    end
  end

  // Stall is masked by reset so an aborted access releases the core at once.
  assign stall    = reset & (((state_q == IDLE) & w_req) | (state_q == WAIT));
  assign err      = (state_q == DONE) & fault_q;
  assign m_rd_dat = m_rd_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_dmem_ctrl
//  Purpose  : Directed bench for riscv_dmem_ctrl in three parameterisations.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  rd_v = 3'b000, wr_v = 3'b000;
  logic [31:0] m_addr = '0, m_wr_dat = '0;
  logic [1:0]  size = 2'b10;
  logic        ld_unsigned = 1'b0;
  logic [31:0] rd0, rd1, rd3;
  logic        st0, st1, st3, er0, er1, er3;
  int          n_checks = 0, n_fail = 0;
  int          sel = 0;
  logic        s_stall, s_err;
  logic [31:0] s_rd;

  always #5 clk = ~clk;

  // dut0: base 0, 64 words, no wait states
  riscv_dmem_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .rd_en(rd_v[0]), .wr_en(wr_v[0]), .m_addr(m_addr),
    .m_wr_dat(m_wr_dat), .size(size), .ld_unsigned(ld_unsigned),
    .m_rd_dat(rd0), .stall(st0), .err(er0));
  // dut1: base 0x1000, 1024 words
  riscv_dmem_ctrl #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(reset), .rd_en(rd_v[1]), .wr_en(wr_v[1]), .m_addr(m_addr),
    .m_wr_dat(m_wr_dat), .size(size), .ld_unsigned(ld_unsigned),
    .m_rd_dat(rd1), .stall(st1), .err(er1));
  // dut3: three wait states
  riscv_dmem_ctrl #(.BASE_ADDR(32'h0), .DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .rd_en(rd_v[2]), .wr_en(wr_v[2]), .m_addr(m_addr),
    .m_wr_dat(m_wr_dat), .size(size), .ld_unsigned(ld_unsigned),
    .m_rd_dat(rd3), .stall(st3), .err(er3));

  assign s_stall = (sel == 0) ? st0 : (sel == 1) ? st1 : st3;
  assign s_err   = (sel == 0) ? er0 : (sel == 1) ? er1 : er3;
  assign s_rd    = (sel == 0) ? rd0 : (sel == 1) ? rd1 : rd3;

  // Drives one access on DUT d and reports stall-cycle count plus DONE-cycle outputs.
  task automatic access(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] dat,
                        input logic [1:0] sz, input bit uns,
                        output int stalls, output logic err_o, output logic [31:0] rd_o);
    bit done = 1'b0;
    sel = d; stalls = 0; err_o = 1'b0; rd_o = '0;
    @(posedge clk); #1;
    m_addr = addr; m_wr_dat = dat; size = sz; ld_unsigned = uns;
    if (wr) wr_v[d] = 1'b1; else rd_v[d] = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (s_stall) stalls++;
      else begin err_o = s_err; rd_o = s_rd; done = 1'b1; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout dut=%0d addr=%h stall never dropped", d, addr);
    end
    @(posedge clk); #1;
    rd_v = 3'b000; wr_v = 3'b000;
  endtask

  task automatic test_reset();
    rd_v = 3'b111;
    repeat (3) @(negedge clk);
    n_checks++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rd0 got=%h exp=00000000", rd0); end
    n_checks++; if (er0 !== 1'b0) begin n_fail++; $display("FAIL reset_err0 got=%b exp=0", er0); end
    n_checks++; if (st0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall0 got=%b exp=0", st0); end
    n_checks++; if (st3 !== 1'b0) begin n_fail++; $display("FAIL reset_stall3 got=%b exp=0", st3); end
    rd_v = 3'b000;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    n_checks++; if (st0 !== 1'b0) begin n_fail++; $display("FAIL idle_stall0 got=%b exp=0", st0); end
  endtask

  task automatic test_word();
    int s; logic e; logic [31:0] r;
    access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, s, e, r);
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL word_st_stall got=%0d exp=1", s); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL word_st_err got=%b exp=0", e); end
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL word_ld_stall got=%0d exp=1", s); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL word_ld_err got=%b exp=0", e); end
    n_checks++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_ld_data got=%h exp=deadbeef", r); end
  endtask

  task automatic test_subword();
    int s; logic e; logic [31:0] r;
    access(0, 1, 32'h10, 32'h0, 2'b10, 0, s, e, r);
    access(0, 1, 32'h13, 32'h12345680, 2'b00, 0, s, e, r);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL byte_st_err got=%b exp=0", e); end
    access(0, 0, 32'h13, 32'h0, 2'b00, 0, s, e, r);
    n_checks++; if (r !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_ld_s got=%h exp=ffffff80", r); end
    access(0, 0, 32'h13, 32'h0, 2'b00, 1, s, e, r);
    n_checks++; if (r !== 32'h00000080) begin n_fail++; $display("FAIL byte_ld_u got=%h exp=00000080", r); end
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL byte_word_ld got=%h exp=80000000", r); end
    access(0, 1, 32'h10, 32'hFFFF7F01, 2'b01, 0, s, e, r);
    access(0, 0, 32'h10, 32'h0, 2'b01, 0, s, e, r);
    n_checks++; if (r !== 32'h00007F01) begin n_fail++; $display("FAIL half_ld_lo got=%h exp=00007f01", r); end
    access(0, 0, 32'h11, 32'h0, 2'b00, 0, s, e, r);
    n_checks++; if (r !== 32'h0000007F) begin n_fail++; $display("FAIL byte_ld_l1 got=%h exp=0000007f", r); end
    access(0, 0, 32'h12, 32'h0, 2'b01, 0, s, e, r);
    n_checks++; if (r !== 32'hFFFF8000) begin n_fail++; $display("FAIL half_ld_hi_s got=%h exp=ffff8000", r); end
    access(0, 0, 32'h12, 32'h0, 2'b01, 1, s, e, r);
    n_checks++; if (r !== 32'h00008000) begin n_fail++; $display("FAIL half_ld_hi_u got=%h exp=00008000", r); end
    access(0, 1, 32'h12, 32'h000000AB, 2'b00, 0, s, e, r);
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'h80AB7F01) begin n_fail++; $display("FAIL lane2_word_ld got=%h exp=80ab7f01", r); end
  endtask

  task automatic test_fault();
    int s; logic e; logic [31:0] r;
    access(0, 1, 32'h20, 32'hCAFEF00D, 2'b10, 0, s, e, r);
    access(0, 0, 32'h21, 32'h0, 2'b01, 0, s, e, r);
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL mis_half_stall got=%0d exp=1", s); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_half_err got=%b exp=1", e); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL mis_half_data got=%h exp=00000000", r); end
    access(0, 1, 32'h22, 32'h11111111, 2'b10, 0, s, e, r);
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL mis_word_stall got=%0d exp=1", s); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_word_err got=%b exp=1", e); end
    access(0, 0, 32'h20, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ram_unchanged got=%h exp=cafef00d", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL ram_unchanged_err got=%b exp=0", e); end
    access(0, 0, 32'h20, 32'h0, 2'b11, 0, s, e, r);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL size11_err got=%b exp=1", e); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL size11_data got=%h exp=00000000", r); end
    access(0, 1, 32'hFC, 32'h600DF00D, 2'b10, 0, s, e, r);
    access(0, 0, 32'hFC, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'h600DF00D || e !== 1'b0) begin n_fail++; $display("FAIL top_word got=%h err=%b exp=600df00d err=0", r, e); end
    access(0, 0, 32'h100, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL range_err got=%b exp=1", e); end
  endtask

  task automatic test_base();
    int s; logic e; logic [31:0] r;
    access(1, 1, 32'h1000, 32'h01020304, 2'b10, 0, s, e, r);
    access(1, 1, 32'h1FFC, 32'h5A5A5A5A, 2'b10, 0, s, e, r);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL base_top_err got=%b exp=0", e); end
    access(1, 1, 32'h2000, 32'hA5A5A5A5, 2'b10, 0, s, e, r);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL base_above_err got=%b exp=1", e); end
    access(1, 1, 32'h0FFC, 32'hA5A5A5A5, 2'b10, 0, s, e, r);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL base_below_err got=%b exp=1", e); end
    access(1, 0, 32'h1000, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'h01020304) begin n_fail++; $display("FAIL base_w0 got=%h exp=01020304", r); end
    access(1, 0, 32'h1FFC, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL base_wlast got=%h exp=5a5a5a5a", r); end
  endtask

  task automatic test_wait();
    int s; logic e; logic [31:0] r;
    access(2, 1, 32'h40, 32'h0BADF00D, 2'b10, 0, s, e, r);
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL ws3_st_stall got=%0d exp=4", s); end
    access(2, 0, 32'h40, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL ws3_ld_stall got=%0d exp=4", s); end
    n_checks++; if (r !== 32'h0BADF00D) begin n_fail++; $display("FAIL ws3_ld_data got=%h exp=0badf00d", r); end
  endtask

  task automatic test_back_to_back();
    sel = 2;
    @(posedge clk); #1;
    m_addr = 32'h40; size = 2'b10; ld_unsigned = 1'b0; rd_v[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (s_stall !== ((i % 5) != 4)) begin
        n_fail++; $display("FAIL b2b_stall cycle=%0d got=%b exp=%b", i, s_stall, (i % 5) != 4);
      end
      if ((i % 5) == 4) begin
        n_checks++;
        if (s_rd !== 32'h0BADF00D || s_err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_data cycle=%0d got=%h err=%b exp=0badf00d err=0", i, s_rd, s_err);
        end
      end
    end
    @(posedge clk); #1; rd_v = 3'b000;
  endtask

  task automatic test_reset_abort();
    int s; logic e; logic [31:0] r;
    sel = 2;
    @(posedge clk); #1;
    m_addr = 32'h40; m_wr_dat = 32'h12345678; size = 2'b10; wr_v[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++; if (s_stall !== 1'b1) begin n_fail++; $display("FAIL abort_pre_stall got=%b exp=1", s_stall); end
    reset = 1'b0;
    #1;
    n_checks++; if (s_stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall got=%b exp=0", s_stall); end
    n_checks++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL abort_err got=%b exp=0", s_err); end
    n_checks++; if (s_rd !== 32'h0) begin n_fail++; $display("FAIL abort_data got=%h exp=00000000", s_rd); end
    @(posedge clk); #1; wr_v = 3'b000;
    @(posedge clk); #1; reset = 1'b1;
    access(2, 0, 32'h40, 32'h0, 2'b10, 0, s, e, r);
    n_checks++; if (r !== 32'h0BADF00D) begin n_fail++; $display("FAIL abort_nowrite got=%h exp=0badf00d", r); end
    n_checks++; if (s !== 4) begin n_fail++; $display("FAIL abort_next_stall got=%0d exp=4", s); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_fault();
    test_base();
    test_wait();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/riscv_dmem_ctrl.md
Name: riscv_dmem_ctrl

Overview:
- Parametrised data-memory controller; successor to the fixed single-cycle data memory on the core's load/store port.
- Adds sub-word access (byte/half/word), sign/zero extension, configurable wait states with a stall handshake to the core, base-address decode and error reporting.
- Sits between riscv_core load/store signals and an internal word-organised RAM array.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- WAIT_STATES, 0, extra stall cycles per access; legal range 0..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rd_en  in  1  load request; held by the core while stall=1.
- wr_en  in  1  store request; held by the core while stall=1.
- m_addr  in  32  byte address; held stable during the request.
- m_wr_dat  in  32  store data, right-aligned.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- ld_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load.
- m_rd_dat  out  32  load result, valid only while state=DONE.
- stall  out  1  core must hold PC and request while high.
- err  out  1  access fault, valid only while state=DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, m_rd_dat=0, err=0, stall=0. RAM contents are not reset. A pending write that has not reached DONE is dropped.
- Request: req = rd_en | wr_en.
- Fault: fault = (rd_en & wr_en) | (size==11) | (size==01 & m_addr[0]) | (size==10 & m_addr[1:0]!=0) | (m_addr < BASE_ADDR) | (m_addr - BASE_ADDR >= DEPTH_WORDS*4).
- stall is combinational: stall = (state==IDLE & req) | (state==WAIT).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - no req: stay in IDLE.
  - req and WAIT_STATES==0: go to DONE.
  - req and WAIT_STATES>0: load counter with WAIT_STATES-1 and go to WAIT.
  - The request is latched on the transition: address offset, size, ld_unsigned, fault, rd/wr.
- WAIT: decrement the counter; when the counter is 0, go to DONE.
- DONE:
  - stall=0.
  - Always returns to IDLE on the next edge, even if req is still high. The core has advanced, so any request seen in the following IDLE cycle is a new one.
- Total access time: WAIT_STATES+2 cycles, of which WAIT_STATES+1 have stall high.
- Memory side effects happen on the edge entering DONE, and only if no fault:
  - store: write byte lanes selected by strobe.
  - load: register the aligned, extended data into m_rd_dat.
- Byte-lane strobes, with off = m_addr[1:0]:
  - byte: 1 << off.
  - half: 0011 (off=0) or 1100 (off=2).
  - word: 1111.
- Store data replication:
  - byte: m_wr_dat[7:0] onto every lane.
  - half: m_wr_dat[15:0] onto both halves.
- Load extraction: select lane(s) by offset, then extend bit 7 (byte) or bit 15 (half) unless ld_unsigned=1. Word loads pass through unchanged.
- On fault: no RAM access, m_rd_dat=0, err=1 for the DONE cycle only. The access timing is identical to a normal access.
- Outside DONE: err=0. m_rd_dat holds its last value; consumers must sample it only in DONE.
- Word index into the RAM: (m_addr - BASE_ADDR) >> 2, width log2(DEPTH_WORDS).
- Reset asserted mid-WAIT: the access is aborted and stall drops asynchronously.

Decomposition:
- Package riscv_mem_pkg holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum (IDLE/WAIT/DONE).
  - lane-mask constants.
- Sub-module riscv_lsu_align, purely combinational, produces:
  - write strobe and replicated write data from size/offset/m_wr_dat.
  - extended load data from the RAM word, size, offset and ld_unsigned.

Test Plan:
- WAIT_STATES=0, BASE_ADDR=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> stall high exactly 1 cycle per access; m_rd_dat=0xDEADBEEF in DONE; err=0.
- Byte store of 0x80 at 0x13 over word 0x00000000, then signed byte load at 0x13 -> 0xFFFFFF80. Unsigned load -> 0x00000080. Word load at 0x10 -> 0x80000000.
- Half load with m_addr=0x21 (size=01) -> err=1 in DONE; m_rd_dat=0; RAM unchanged. Same timing for a word store at 0x22.
- BASE_ADDR=0x1000, DEPTH_WORDS=1024: store to 0x2000, and separately to 0x0FFC -> err=1, no write; store to 0x1FFC succeeds.
- WAIT_STATES=3: word load -> stall high for 4 consecutive cycles, DONE on the 5th cycle; back-to-back loads each take 5 cycles.
- WAIT_STATES=3: word store 0x12345678 to 0x40; drive reset=0 during the second WAIT cycle -> stall=0, err=0 and m_rd_dat=0 immediately. A later load of 0x40 returns the prior contents, not 0x12345678.
